// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: fetches a word over a req/ack handshake,
// holds it for decode during EXEC, then resolves the next PC from the decoded op.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic [5:0]  CUOp,
    input  logic [31:0] immOut,
    input  logic [31:0] rs1_data,
    input  logic        branch_taken,
    input  logic        stall,
    output logic        halted,
    output logic        misaligned,
    output logic        fetch_timeout
);

    localparam logic [5:0] CU_JAL   = 6'd2;
    localparam logic [5:0] CU_JALR  = 6'd3;
    localparam logic [5:0] CU_BEQ   = 6'd4;
    localparam logic [5:0] CU_BGEU  = 6'd9;
    localparam logic [5:0] CU_ERROR = 6'd38;

    localparam int unsigned     CNT_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        FETCH    = 2'd1,
        EXEC     = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic              tmo_q, tmo_d;
    logic [31:0]       next_pc;

    // Target selection; JALR clears bit 0 before the alignment check sees it.
    function automatic logic [31:0] calc_next_pc(
        input logic [5:0]  op,
        input logic [31:0] cur_pc,
        input logic [31:0] imm,
        input logic [31:0] rs1,
        input logic        taken
    );
        logic [31:0] sum;
        if (op == CU_JAL) begin
            calc_next_pc = cur_pc + imm;
        end else if (op == CU_JALR) begin
            sum          = rs1 + imm;
            calc_next_pc = {sum[31:1], 1'b0};
        end else if ((op >= CU_BEQ) && (op <= CU_BGEU) && taken) begin
            calc_next_pc = cur_pc + imm;
        end else begin
            calc_next_pc = cur_pc + 32'd4;
        end
    endfunction

    assign next_pc = calc_next_pc(CUOp, pc_q, immOut, rs1_data, branch_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_HOLD;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        tmo_d   = tmo_q;
        case (state_q)
            RST_HOLD: begin
                state_d = FETCH;
            end
            FETCH: begin
                // An ack on the threshold cycle still completes the fetch.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (CUOp == CU_ERROR) begin
                        state_d = HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign imem_req      = (state_q == FETCH);
    assign instr_valid   = (state_q == EXEC);
    assign halted        = (state_q == HALT);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign link_addr     = pc_q + 32'd4;
    assign instr         = instr_q;
    assign misaligned    = mis_q;
    assign fetch_timeout = tmo_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written reset/timeout/error
// sequences, and a randomized instruction stream checked against a next-PC model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 4;

    localparam logic [5:0] OP_ADDI  = 6'd18;
    localparam logic [5:0] OP_ADD   = 6'd27;
    localparam logic [5:0] OP_LW    = 6'd12;
    localparam logic [5:0] OP_JAL   = 6'd2;
    localparam logic [5:0] OP_JALR  = 6'd3;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLTU  = 6'd8;
    localparam logic [5:0] OP_ERROR = 6'd38;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [5:0]  CUOp = 6'd0;
    logic [31:0] immOut = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic        branch_taken = 1'b0;
    logic        stall = 1'b0;
    logic        halted;
    logic        misaligned;
    logic        fetch_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    bit          m_halted;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .link_addr(link_addr),
        .CUOp(CUOp), .immOut(immOut), .rs1_data(rs1_data),
        .branch_taken(branch_taken), .stall(stall),
        .halted(halted), .misaligned(misaligned), .fetch_timeout(fetch_timeout)
    );

    typedef struct {
        logic [31:0] word;
        int          lat;
        logic [5:0]  op;
        logic [31:0] imm;
        logic [31:0] rs1;
        bit          taken;
        int          stalls;
        logic [31:0] exp_next;
        bit          exp_halt;
        bit          exp_mis;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next-PC reference from the architectural rules, using plain arithmetic.
    task automatic ref_next(input logic [5:0] op, input logic [31:0] cur, input logic [31:0] imm,
                            input logic [31:0] rs1, input bit taken,
                            output logic [31:0] nxt, output bit halt, output bit mis);
        logic [31:0] tgt;
        halt = 1'b0;
        mis  = 1'b0;
        nxt  = cur;
        if (op == OP_ERROR) begin
            halt = 1'b1;
        end else begin
            if (op == OP_JAL) tgt = cur + imm;
            else if (op == OP_JALR) begin
                tgt = rs1 + imm;
                tgt = tgt - (tgt % 2);
            end else if (op >= 6'd4 && op <= 6'd9 && taken) tgt = cur + imm;
            else tgt = cur + 4;
            if (tgt % 4 != 0) begin
                halt = 1'b1;
                mis  = 1'b1;
            end else begin
                nxt = tgt;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        CUOp = 6'd0;
        tick();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_mis", misaligned, 1'b0);
        chk("rst_tmo", fetch_timeout, 1'b0);
        rst = 1'b0;
        #1;
        chk("hold_req", imem_req, 1'b0);
        tick();
        chk("first_req", imem_req, 1'b1);
        m_pc = RST_PC;
        m_halted = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] word, input int lat, input logic [5:0] op,
                             input logic [31:0] imm, input logic [31:0] rs1, input bit taken,
                             input int stalls, input logic [31:0] exp_next,
                             input bit exp_halt, input bit exp_mis);
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            tick();
            chk("wait_req", imem_req, 1'b1);
            chk("wait_valid", instr_valid, 1'b0);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        chk("exec_valid", instr_valid, 1'b1);
        chk("exec_instr", instr, word);
        chk("exec_pc", pc, m_pc);
        chk("exec_link", link_addr, m_pc + 32'd4);
        chk("exec_req", imem_req, 1'b0);
        chk("exec_tmo", fetch_timeout, 1'b0);
        CUOp = op;
        immOut = imm;
        rs1_data = rs1;
        branch_taken = taken;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            imem_ack = 1'b1;
            tick();
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, word);
        end
        stall = 1'b0;
        imem_ack = 1'b0;
        tick();
        chk("post_valid", instr_valid, 1'b0);
        chk("post_halted", halted, exp_halt);
        chk("post_mis", misaligned, exp_mis);
        if (exp_halt) begin
            chk("halt_req", imem_req, 1'b0);
            chk("halt_pc", pc, m_pc);
            m_halted = 1'b1;
        end else begin
            chk("next_req", imem_req, 1'b1);
            chk("next_addr", imem_addr, exp_next);
            m_pc = exp_next;
        end
    endtask

    initial begin
        logic [31:0] r_word, r_imm, r_rs1, r_nxt;
        logic [5:0]  r_op;
        bit          r_taken, r_halt, r_mis;

        tbl[0]  = '{32'h0000_0033, 1, OP_ADD,  32'h0,         32'h0,      1'b0, 0, 32'h004, 1'b0, 1'b0};
        tbl[1]  = '{32'h0100_0013, 1, OP_ADDI, 32'h10,        32'h0,      1'b0, 3, 32'h008, 1'b0, 1'b0};
        tbl[2]  = '{32'h0080_2003, 1, OP_LW,   32'h8,         32'h0,      1'b1, 0, 32'h00C, 1'b0, 1'b0};
        tbl[3]  = '{32'h0F40_006F, 0, OP_JAL,  32'hF4,        32'h0,      1'b0, 0, 32'h100, 1'b0, 1'b0};
        tbl[4]  = '{32'hFF1F_F06F, 2, OP_JAL,  32'hFFFF_FFF0, 32'h0,      1'b0, 1, 32'h0F0, 1'b0, 1'b0};
        tbl[5]  = '{32'h0010_8067, 3, OP_JALR, 32'h1,         32'h1FF,    1'b0, 0, 32'h200, 1'b0, 1'b0};
        tbl[6]  = '{32'h0400_1063, 1, OP_BNE,  32'h40,        32'h0,      1'b1, 0, 32'h240, 1'b0, 1'b0};
        tbl[7]  = '{32'hFC1F_F06F, 0, OP_JAL,  32'hFFFF_FFC0, 32'h0,      1'b0, 0, 32'h200, 1'b0, 1'b0};
        tbl[8]  = '{32'h0400_1063, 1, OP_BNE,  32'h40,        32'h0,      1'b0, 2, 32'h204, 1'b0, 1'b0};
        tbl[9]  = '{32'hFE00_6EE3, 1, OP_BLTU, 32'hFFFF_FFFC, 32'h0,      1'b1, 0, 32'h200, 1'b0, 1'b0};
        tbl[10] = '{32'h0080_006F, 1, OP_JAL,  32'h8,         32'h0,      1'b0, 0, 32'h208, 1'b0, 1'b0};
        tbl[11] = '{32'h0020_8067, 1, OP_JALR, 32'h2,         32'h1001,   1'b0, 0, 32'h208, 1'b1, 1'b1};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].word, tbl[i].lat, tbl[i].op, tbl[i].imm, tbl[i].rs1, tbl[i].taken,
                      tbl[i].stalls, tbl[i].exp_next, tbl[i].exp_halt, tbl[i].exp_mis);
        end
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            tick();
            chk("absorb_req", imem_req, 1'b0);
            chk("absorb_halted", halted, 1'b1);
            chk("absorb_pc", pc, 32'h208);
        end
        imem_ack = 1'b0;

        // Error opcode halts without touching pc or the misaligned flag.
        do_reset();
        run_instr(32'hFFFF_FFFF, 1, OP_ERROR, 32'h40, 32'h0, 1'b1, 0, 32'h0, 1'b1, 1'b0);
        chk("err_tmo", fetch_timeout, 1'b0);

        // No ack at all: four FETCH cycles, then timeout.
        do_reset();
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_wait_req", imem_req, 1'b1);
            chk("tmo_wait_flag", fetch_timeout, 1'b0);
            if (i < TMO - 1) tick();
        end
        tick();
        chk("tmo_flag", fetch_timeout, 1'b1);
        chk("tmo_halted", halted, 1'b1);
        chk("tmo_req", imem_req, 1'b0);
        chk("tmo_mis", misaligned, 1'b0);

        // Reset mid-FETCH at a non-reset pc; a late ack is ignored.
        do_reset();
        run_instr(32'h1000_006F, 1, OP_JAL, 32'h100, 32'h0, 1'b0, 0, 32'h100, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_pc", pc, RST_PC);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        tick();
        chk("late_ack_instr", instr, 32'd0);
        chk("late_ack_valid", instr_valid, 1'b0);
        chk("late_ack_req", imem_req, 1'b1);
        chk("late_ack_addr", imem_addr, RST_PC);
        imem_ack = 1'b0;
        m_pc = RST_PC;
        m_halted = 1'b0;

        // Randomized stream against the model; reset whenever it halts.
        for (int k = 0; k < 80; k++) begin
            if (m_halted) do_reset();
            r_word = $urandom;
            r_op = 6'($urandom_range(0, 38));
            if ($urandom_range(0, 7) == 0) r_imm = $urandom;
            else r_imm = ($urandom_range(0, 511) - 256) * 4;
            if ($urandom_range(0, 5) == 0) r_rs1 = $urandom;
            else r_rs1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            r_taken = 1'($urandom_range(0, 1));
            ref_next(r_op, m_pc, r_imm, r_rs1, r_taken, r_nxt, r_halt, r_mis);
            run_instr(r_word, $urandom_range(0, TMO - 1), r_op, r_imm, r_rs1, r_taken,
                      $urandom_range(0, 2), r_nxt, r_halt, r_mis);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
